// File: rtl/led_anim_pkg.sv
// Shared constants and helpers for the LED animation engine.
// Mode encodings, direction values and per-mode start patterns.
package led_anim_pkg;

    localparam logic [2:0] SHIFT_L  = 3'd0;
    localparam logic [2:0] SHIFT_R  = 3'd1;
    localparam logic [2:0] PINGPONG = 3'd2;
    localparam logic [2:0] FILL     = 3'd3;
    localparam logic [2:0] BLINK    = 3'd4;
    localparam int         N_MODES  = 5;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Result is 32 bits wide; callers truncate to their bar width.
    function automatic logic [31:0] init_pattern(
        input logic [2:0] m,
        input int         n
    );
        logic [31:0] ones;
        ones = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        case (m)
            SHIFT_R: return 32'd1 << (n - 1);
            FILL:    return 32'd0;
            BLINK:   return ones;
            default: return 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/led_anim_step.sv
// Combinational next-pattern arithmetic for one animation step.
// Also detects corrupted patterns and reloads the mode's start value.
module led_anim_step
    import led_anim_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   mode,
    input  logic [N-1:0] led,
    input  logic         dir,
    output logic [N-1:0] next_led,
    output logic         next_dir,
    output logic         wrap_n
);

    logic         one_hot;
    logic         thermo;
    logic         all_one;
    logic         go_left;
    logic [N-1:0] init_led;
    logic [N-1:0] pp_led;

    assign one_hot  = $onehot(led);
    // Low-aligned run of ones: adding one clears every set bit.
    assign thermo   = ((led & (led + N'(1))) == '0);
    assign all_one  = &led;
    assign init_led = N'(init_pattern(mode, N));

    assign go_left = (dir == LEFT && !led[N-1]) ||
                     (dir == RIGHT && led[0]);
    assign pp_led  = go_left ? (led << 1) : (led >> 1);

    always_comb begin
        next_led = led;
        next_dir = dir;
        wrap_n   = 1'b0;
        case (mode)
            SHIFT_L: begin
                if (!one_hot) begin
                    next_led = init_led;
                end else begin
                    next_led = {led[N-2:0], led[N-1]};
                    wrap_n   = led[N-1];
                end
            end
            SHIFT_R: begin
                if (!one_hot) begin
                    next_led = init_led;
                end else begin
                    next_led = {led[0], led[N-1:1]};
                    wrap_n   = led[0];
                end
            end
            PINGPONG: begin
                if (!one_hot) begin
                    next_led = init_led;
                    next_dir = LEFT;
                end else begin
                    next_led = pp_led;
                    if (pp_led[N-1])
                        next_dir = RIGHT;
                    else if (pp_led[0])
                        next_dir = LEFT;
                    else
                        next_dir = go_left ? LEFT : RIGHT;
                    wrap_n = pp_led[0] && !go_left;
                end
            end
            FILL: begin
                if (!thermo) begin
                    next_led = init_led;
                end else if (all_one) begin
                    next_led = '0;
                    wrap_n   = 1'b1;
                end else begin
                    next_led = {led[N-2:0], 1'b1};
                end
            end
            BLINK: begin
                next_led = ~led;
                wrap_n   = &(~led);
            end
            default: begin
                next_led = led;
            end
        endcase
    end

endmodule

// File: rtl/led_anim_engine.sv
// Tick-driven LED pattern generator with mode cycling and pause.
// Holds the registers and event priority; step math lives in led_anim_step.
module led_anim_engine
    import led_anim_pkg::*;
#(
    parameter int N_LEDS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              mode_next,
    input  logic              pause_tgl,
    output logic [N_LEDS-1:0] led,
    output logic [2:0]        mode,
    output logic              paused,
    output logic              wrap
);

    logic              dir;
    logic [N_LEDS-1:0] next_led;
    logic              next_dir;
    logic              wrap_n;
    logic [2:0]        mode_inc;

    assign mode_inc = (mode == BLINK) ? SHIFT_L : mode + 3'd1;

    led_anim_step #(
        .N (N_LEDS)
    ) u_step (
        .mode     (mode),
        .led      (led),
        .dir      (dir),
        .next_led (next_led),
        .next_dir (next_dir),
        .wrap_n   (wrap_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            led    <= N_LEDS'(1);
            mode   <= SHIFT_L;
            paused <= 1'b0;
            wrap   <= 1'b0;
            dir    <= LEFT;
        end else if (mode > BLINK) begin
            // Unreachable encodings fall back to a clean SHIFT_L start.
            led  <= N_LEDS'(init_pattern(SHIFT_L, N_LEDS));
            mode <= SHIFT_L;
            wrap <= 1'b0;
            dir  <= LEFT;
        end else if (mode_next) begin
            led  <= N_LEDS'(init_pattern(mode_inc, N_LEDS));
            mode <= mode_inc;
            wrap <= 1'b0;
            dir  <= LEFT;
        end else if (pause_tgl) begin
            paused <= ~paused;
            wrap   <= 1'b0;
        end else if (tick && !paused) begin
            led  <= next_led;
            dir  <= next_dir;
            wrap <= wrap_n;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
